id_ex_operand_stage: RTL and testbench
======================================

Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register for the pipelined datapath. Sits directly upstream of the ALU and drives its reg1, reg2 and ALUop inputs every cycle.
- Captures decoded operands and control from ID and extends the immediate.
- Resolves data hazards: forwards from EX/MEM and MEM/WB, and detects load-use hazards, inserting a bubble while ID holds.

Parameters:
- DATA_W, 32, datapath width.
- RA_W, 5, register-number width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- id_valid  in  1  ID holds a real instruction.
- id_rs, id_rt, id_rd  in  RA_W each  decoded register numbers.
- id_rs_data, id_rt_data  in  DATA_W each  register-file read data.
- id_imm  in  16  raw immediate.
- id_alu_op  in  3  000 AND, 001 OR, 010 ADD, 110 SUB, 011 LUI, 111 SLT.
- id_alu_src  in  1  1 selects the extended immediate as reg2.
- id_reg_dst  in  1  1 selects rd, 0 selects rt as destination.
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  in  1 each  control bits.
- id_uses_rt  in  1  instruction reads rt (R-type, branch, store).
- flush  in  1  squash the instruction entering EX.
- hold  in  1  downstream stall: freeze this stage.
- exmem_reg_write  in  1;  exmem_rd  in  RA_W;  exmem_result  in  DATA_W.
- memwb_reg_write  in  1;  memwb_rd  in  RA_W;  memwb_result  in  DATA_W.
- load_use_stall  out  1  to IF/ID: hold PC and IF/ID register.
- alu_reg1, alu_reg2  out  DATA_W each  to ALU reg1/reg2.
- alu_op  out  3  to ALU ALUop.
- ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  out  1 each.
- ex_dest  out  RA_W  destination register.
- ex_store_data  out  DATA_W  forwarded rt value, for stores.

Behaviour:
- All registered state updates on the rising clk edge.
- Update priority per edge: reset > flush > hold > load_use_stall > normal capture.
- Reset loads all registers with 0: ex_valid=0, alu_op=000, all controls 0, ex_dest=0. alu_reg1, alu_reg2 and ex_store_data then read 0.
- Flush and load_use_stall each load a bubble: ex_valid=0, all write/mem controls 0, alu_op=000, data fields 0.
- Hold keeps every register unchanged. Flush during hold still squashes.
- Normal capture registers all id_* fields, with one cycle latency ID to EX.
- Stored destination is id_reg_dst ? id_rd : id_rt.
- Stored immediate depends on id_alu_op:
  - ADD, SUB, SLT: sign-extended.
  - AND, OR, LUI: zero-extended. The ALU performs the LUI shift.
- If id_valid=0 at capture, a bubble is stored.
- load_use_stall is combinational, asserted when all of the following hold:
  - ex_valid & ex_mem_read & id_valid.
  - ex_dest != 0.
  - ex_dest == id_rs, or (id_uses_rt & ex_dest == id_rt).
- load_use_stall is forced 0 while hold or flush is high.
- Forwarding is combinational on the registered rs/rt numbers of the EX instruction. For each source s:
  - exmem_reg_write & exmem_rd != 0 & exmem_rd == s → exmem_result.
  - else memwb_reg_write & memwb_rd != 0 & memwb_rd == s → memwb_result.
  - else the registered register-file data.
  - EX/MEM always wins when both match.
- Register 0 is never forwarded.
- Operand outputs:
  - alu_reg1 = forwarded rs.
  - ex_store_data = forwarded rt.
  - alu_reg2 = registered immediate if alu_src, else forwarded rt.
- alu_op always equals the registered op. A bubble yields 0 AND 0 = 0 at the ALU.
- The register file is write-before-read, so no forwarding is needed from the stage past WB.

Test Plan:
- Reset held 2 cycles with arbitrary id_* inputs → after the edge: ex_valid=0, alu_op=000, alu_reg1=alu_reg2=0, load_use_stall=0.
- Capture: id_alu_op=010, alu_src=1, imm=16'hFFFC, rs_data=100 → next cycle alu_reg1=100, alu_reg2=32'hFFFFFFFC. Repeat with op=001 → alu_reg2=32'h0000FFFC.
- Double forward: EX rs=5; exmem_rd=5 (result 7) and memwb_rd=5 (result 9), both with reg_write=1 → alu_reg1=7. Drop exmem_reg_write → alu_reg1=9. Set rs=0 with exmem_rd=0 → register-file value is used.
- Load-use: EX holds lw to $8; ID add reads $8 with uses_rt=1 → load_use_stall=1 the same cycle. Next cycle ex_valid=0 and load_use_stall=0. The held add is then captured, and a MEM/WB forward supplies $8.
- Flush and hold together: hold=1 for 3 cycles with changing id_* → outputs constant. Then flush=1 with hold=1 → bubble next cycle, and load_use_stall is suppressed.
- Mid-operation reset: reset asserted while EX holds a valid sub with forwarding active → next cycle every output reads its reset value.

Source files
------------

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with immediate extension, operand forwarding
// and load-use hazard detection feeding the ALU.
module id_ex_operand_stage #(
    parameter int DATA_W = 32,
    parameter int RA_W   = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [RA_W-1:0]   id_rs,
    input  logic [RA_W-1:0]   id_rt,
    input  logic [RA_W-1:0]   id_rd,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [15:0]       id_imm,
    input  logic [2:0]        id_alu_op,
    input  logic              id_alu_src,
    input  logic              id_reg_dst,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_mem_to_reg,
    input  logic              id_uses_rt,
    input  logic              flush,
    input  logic              hold,
    input  logic              exmem_reg_write,
    input  logic [RA_W-1:0]   exmem_rd,
    input  logic [DATA_W-1:0] exmem_result,
    input  logic              memwb_reg_write,
    input  logic [RA_W-1:0]   memwb_rd,
    input  logic [DATA_W-1:0] memwb_result,
    output logic              load_use_stall,
    output logic [DATA_W-1:0] alu_reg1,
    output logic [DATA_W-1:0] alu_reg2,
    output logic [2:0]        alu_op,
    output logic              ex_valid,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_mem_to_reg,
    output logic [RA_W-1:0]   ex_dest,
    output logic [DATA_W-1:0] ex_store_data
);

    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              mem_to_reg;
        logic              alu_src;
        logic [2:0]        alu_op;
        logic [RA_W-1:0]   dest;
        logic [RA_W-1:0]   rs;
        logic [RA_W-1:0]   rt;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm;
    } id_ex_t;

    id_ex_t            ex_q;
    id_ex_t            cap;
    logic              sign_ext;
    logic [DATA_W-1:0] imm_ext;
    logic              rs_hit;
    logic              rt_hit;
    logic [DATA_W-1:0] fwd_rs;
    logic [DATA_W-1:0] fwd_rt;

    // Arithmetic ops take a signed immediate; logical ops and LUI do not.
    assign sign_ext = (id_alu_op == OP_ADD) || (id_alu_op == OP_SUB)
                   || (id_alu_op == OP_SLT);

    assign imm_ext = sign_ext
        ? {{(DATA_W-16){id_imm[15]}}, id_imm}
        : {{(DATA_W-16){1'b0}}, id_imm};

    always_comb begin
        cap = '0;
        if (id_valid) begin
            cap.valid      = 1'b1;
            cap.reg_write  = id_reg_write;
            cap.mem_read   = id_mem_read;
            cap.mem_write  = id_mem_write;
            cap.mem_to_reg = id_mem_to_reg;
            cap.alu_src    = id_alu_src;
            cap.alu_op     = id_alu_op;
            cap.dest       = id_reg_dst ? id_rd : id_rt;
            cap.rs         = id_rs;
            cap.rt         = id_rt;
            cap.rs_data    = id_rs_data;
            cap.rt_data    = id_rt_data;
            cap.imm        = imm_ext;
        end
    end

    assign rs_hit = (ex_q.dest == id_rs);
    assign rt_hit = id_uses_rt && (ex_q.dest == id_rt);

    assign load_use_stall = ex_q.valid && ex_q.mem_read && id_valid
                         && (ex_q.dest != '0) && (rs_hit || rt_hit)
                         && !hold && !flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q <= '0;
        end else if (flush) begin
            ex_q <= '0;
        end else if (!hold) begin
            if (load_use_stall) ex_q <= '0;
            else                ex_q <= cap;
        end
    end

    // EX/MEM is the younger producer, so it takes precedence over MEM/WB.
    function automatic logic [DATA_W-1:0] fwd(
        input logic [RA_W-1:0]   src,
        input logic [DATA_W-1:0] rf
    );
        logic [DATA_W-1:0] v;
        v = rf;
        if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == src))
            v = exmem_result;
        else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == src))
            v = memwb_result;
        return v;
    endfunction

    assign fwd_rs = fwd(ex_q.rs, ex_q.rs_data);
    assign fwd_rt = fwd(ex_q.rt, ex_q.rt_data);

    assign alu_reg1      = fwd_rs;
    assign alu_reg2      = ex_q.alu_src ? ex_q.imm : fwd_rt;
    assign ex_store_data = fwd_rt;
    assign alu_op        = ex_q.alu_op;
    assign ex_valid      = ex_q.valid;
    assign ex_reg_write  = ex_q.reg_write;
    assign ex_mem_read   = ex_q.mem_read;
    assign ex_mem_write  = ex_q.mem_write;
    assign ex_mem_to_reg = ex_q.mem_to_reg;
    assign ex_dest       = ex_q.dest;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Scoreboard bench for id_ex_operand_stage: a spec-level model predicts
// each post-edge output set, which is queued and compared after the edge.
module tb_id_ex_operand_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [31:0] id_rs_data, id_rt_data;
    logic [15:0] id_imm;
    logic [2:0]  id_alu_op;
    logic        id_alu_src, id_reg_dst, id_reg_write;
    logic        id_mem_read, id_mem_write, id_mem_to_reg, id_uses_rt;
    logic        flush, hold;
    logic        exmem_reg_write, memwb_reg_write;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_result, memwb_result;
    logic        load_use_stall;
    logic [31:0] alu_reg1, alu_reg2, ex_store_data;
    logic [2:0]  alu_op;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
    logic        ex_mem_to_reg;
    logic [4:0]  ex_dest;

    always #5 clk = ~clk;

    id_ex_operand_stage dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_imm(id_imm), .id_alu_op(id_alu_op),
        .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
        .id_uses_rt(id_uses_rt), .flush(flush), .hold(hold),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd),
        .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd),
        .memwb_result(memwb_result),
        .load_use_stall(load_use_stall),
        .alu_reg1(alu_reg1), .alu_reg2(alu_reg2), .alu_op(alu_op),
        .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_dest(ex_dest),
        .ex_store_data(ex_store_data)
    );

    typedef struct {
        logic        valid, rw, mr, mw, m2r;
        logic [2:0]  op;
        logic [4:0]  dest;
        logic [31:0] r1, r2, sd;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference state of the EX instruction.
    logic        m_valid, m_rw, m_mr, m_mw, m_m2r, m_src;
    logic [2:0]  m_op;
    logic [4:0]  m_dest, m_rs, m_rt;
    logic [31:0] m_rsd, m_rtd, m_imm;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    function automatic logic [31:0] m_fwd(input logic [4:0] s,
                                          input logic [31:0] d);
        if (exmem_reg_write && exmem_rd != 0 && exmem_rd == s)
            return exmem_result;
        if (memwb_reg_write && memwb_rd != 0 && memwb_rd == s)
            return memwb_result;
        return d;
    endfunction

    function automatic logic m_stall();
        logic hit;
        hit = (m_dest == id_rs) || (id_uses_rt && m_dest == id_rt);
        return m_valid && m_mr && id_valid && m_dest != 0 && hit
            && !hold && !flush;
    endfunction

    task automatic m_bubble();
        {m_valid, m_rw, m_mr, m_mw, m_m2r, m_src} = '0;
        m_op = 0; m_dest = 0; m_rs = 0; m_rt = 0;
        m_rsd = 0; m_rtd = 0; m_imm = 0;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, rt, rd,
                          input logic [31:0] rsd, rtd,
                          input logic [15:0] imm, input logic [2:0] op,
                          input logic src, dst, rw, mr, mw, m2r, urt);
        id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
        id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;
        id_alu_op = op; id_alu_src = src; id_reg_dst = dst;
        id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
        id_mem_to_reg = m2r; id_uses_rt = urt;
    endtask

    task automatic set_fwd(input logic erw, input logic [4:0] erd,
                           input logic [31:0] ers, input logic mrw,
                           input logic [4:0] mrd, input logic [31:0] mrs);
        exmem_reg_write = erw; exmem_rd = erd; exmem_result = ers;
        memwb_reg_write = mrw; memwb_rd = mrd; memwb_result = mrs;
    endtask

    // One clock: check the stall, advance the model, queue and compare.
    task automatic cycle();
        logic st;
        exp_t e, g;
        #1;
        st = m_stall();
        chk("stall", {31'b0, load_use_stall}, {31'b0, st});
        if (reset || flush) m_bubble();
        else if (hold) ;
        else if (st || !id_valid) m_bubble();
        else begin
            m_valid = 1; m_rw = id_reg_write; m_mr = id_mem_read;
            m_mw = id_mem_write; m_m2r = id_mem_to_reg;
            m_src = id_alu_src; m_op = id_alu_op;
            m_dest = id_reg_dst ? id_rd : id_rt;
            m_rs = id_rs; m_rt = id_rt;
            m_rsd = id_rs_data; m_rtd = id_rt_data;
            if (id_alu_op inside {3'b010, 3'b110, 3'b111})
                m_imm = {{16{id_imm[15]}}, id_imm};
            else
                m_imm = {16'h0, id_imm};
        end
        e.valid = m_valid; e.rw = m_rw; e.mr = m_mr; e.mw = m_mw;
        e.m2r = m_m2r; e.op = m_op; e.dest = m_dest;
        e.r1 = m_fwd(m_rs, m_rsd);
        e.sd = m_fwd(m_rt, m_rtd);
        e.r2 = m_src ? m_imm : e.sd;
        sb.push_back(e);
        @(posedge clk);
        #1;
        g = sb.pop_front();
        chk("ex_valid", {31'b0, ex_valid}, {31'b0, g.valid});
        chk("ctrl", {28'b0, ex_reg_write, ex_mem_read, ex_mem_write,
                     ex_mem_to_reg}, {28'b0, g.rw, g.mr, g.mw, g.m2r});
        chk("alu_op", {29'b0, alu_op}, {29'b0, g.op});
        chk("ex_dest", {27'b0, ex_dest}, {27'b0, g.dest});
        chk("alu_reg1", alu_reg1, g.r1);
        chk("alu_reg2", alu_reg2, g.r2);
        chk("store_data", ex_store_data, g.sd);
    endtask

    initial begin
        m_bubble();
        reset = 1; flush = 0; hold = 0;
        set_fwd(1, 3, 32'h11, 1, 4, 32'h22);
        set_id(1, 3, 4, 6, 32'hAAAA, 32'hBBBB, 16'h1234, 3'b010,
               0, 1, 1, 1, 1, 1, 1);
        cycle();
        set_id(1, 7, 8, 9, 32'h5, 32'h6, 16'h8000, 3'b111,
               1, 0, 1, 0, 0, 0, 1);
        cycle();
        chk("rst_reg1", alu_reg1, 32'h0);
        chk("rst_reg2", alu_reg2, 32'h0);

        // Immediate extension.
        reset = 0;
        set_fwd(0, 0, 0, 0, 0, 0);
        set_id(1, 3, 4, 6, 32'd100, 32'd1, 16'hFFFC, 3'b010,
               1, 0, 1, 0, 0, 0, 0);
        cycle();
        chk("add_reg1", alu_reg1, 32'd100);
        chk("add_sext", alu_reg2, 32'hFFFF_FFFC);
        id_alu_op = 3'b001;
        cycle();
        chk("or_zext", alu_reg2, 32'h0000_FFFC);
        id_alu_op = 3'b111;
        id_imm = 16'h7FFF;
        cycle();

        // Forwarding priority and register 0.
        set_id(1, 5, 6, 7, 32'd55, 32'd66, 16'h0, 3'b010,
               0, 1, 1, 0, 0, 0, 1);
        set_fwd(1, 5, 32'd7, 1, 5, 32'd9);
        cycle();
        chk("fwd_exmem", alu_reg1, 32'd7);
        hold = 1;
        set_fwd(0, 5, 32'd7, 1, 5, 32'd9);
        cycle();
        chk("fwd_memwb", alu_reg1, 32'd9);
        hold = 0;
        set_id(1, 0, 6, 7, 32'd44, 32'd66, 16'h0, 3'b000,
               0, 1, 1, 0, 0, 0, 1);
        set_fwd(1, 0, 32'd7, 1, 6, 32'd123);
        cycle();
        chk("fwd_r0", alu_reg1, 32'd44);
        chk("fwd_rt", ex_store_data, 32'd123);

        // Load-use hazard.
        set_fwd(0, 0, 0, 0, 0, 0);
        set_id(1, 2, 8, 0, 32'd1000, 32'd0, 16'h0004, 3'b010,
               1, 0, 1, 1, 0, 1, 0);
        cycle();
        set_id(1, 9, 8, 10, 32'd3, 32'd1234, 16'h0, 3'b010,
               0, 1, 1, 0, 0, 0, 1);
        #1;
        chk("lu_stall", {31'b0, load_use_stall}, 32'd1);
        cycle();
        chk("lu_bubble", {31'b0, ex_valid}, 32'd0);
        set_fwd(0, 0, 0, 1, 8, 32'hBEEF);
        cycle();
        chk("lu_fwd", alu_reg2, 32'hBEEF);

        // Hold freezes a load in EX; flush under hold squashes it.
        set_fwd(0, 0, 0, 0, 0, 0);
        set_id(1, 1, 12, 0, 32'd1, 32'd0, 16'hFFF0, 3'b010,
               1, 0, 1, 1, 0, 1, 0);
        cycle();
        hold = 1;
        for (int i = 0; i < 3; i++) begin
            set_id(1, 12, 12, 5'(i), $urandom, $urandom, 16'($urandom),
                   3'b110, 0, 1, 1, 0, 1, 0, 1);
            cycle();
            chk("hold_reg2", alu_reg2, 32'hFFFF_FFF0);
        end
        flush = 1;
        #1;
        chk("flush_nostall", {31'b0, load_use_stall}, 32'd0);
        cycle();
        chk("flush_bubble", {31'b0, ex_valid}, 32'd0);
        flush = 0; hold = 0;

        // Reset mid-operation with forwarding active.
        set_id(1, 4, 5, 6, 32'd10, 32'd20, 16'h0, 3'b110,
               0, 1, 1, 0, 0, 0, 1);
        set_fwd(1, 4, 32'd77, 1, 5, 32'd88);
        cycle();
        chk("sub_fwd", alu_reg1, 32'd77);
        reset = 1;
        cycle();
        chk("mid_rst_reg1", alu_reg1, 32'd0);
        chk("mid_rst_op", {29'b0, alu_op}, 32'd0);
        reset = 0;
        set_id(0, 4, 5, 6, 32'd10, 32'd20, 16'h0, 3'b110,
               0, 1, 1, 0, 0, 0, 1);
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
